// File: rtl/traffic_scheduler_gmii.sv
// traffic_scheduler_gmii
// Holds frame transmission until a programmed rtclock start time, then
// launches one generator frame every eff_ivl cycles. It stops after the
// programmed count, or on ctrl_stop, and counts launch slots lost to a
// busy generator. All outputs are registered.
module traffic_scheduler_gmii #(
    parameter int CNT_WIDTH = 32,
    parameter int IVL_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [47:0]          sec,
    input  logic [29:0]          nsec,
    input  logic [47:0]          cfg_start_sec,
    input  logic [29:0]          cfg_start_nsec,
    input  logic [CNT_WIDTH-1:0] cfg_frames,
    input  logic [IVL_WIDTH-1:0] cfg_interval,
    input  logic                 ctrl_start,
    input  logic                 ctrl_stop,
    input  logic                 tg_busy,
    output logic                 tg_start,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] frames_sent,
    output logic [CNT_WIDTH-1:0] late_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_ISSUE = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [IVL_WIDTH-1:0] IVL_ZERO = {IVL_WIDTH{1'b0}};
    localparam logic [IVL_WIDTH-1:0] IVL_ONE  = IVL_WIDTH'(1);
    localparam logic [IVL_WIDTH-1:0] IVL_MIN  = IVL_WIDTH'(2);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [47:0]          r_start_sec;
    logic [29:0]          r_start_nsec;
    logic [CNT_WIDTH-1:0] r_frames;
    logic [IVL_WIDTH-1:0] r_ivl;
    logic [IVL_WIDTH-1:0] r_timer;
    logic [IVL_WIDTH-1:0] w_timer_nxt;
    logic [IVL_WIDTH-1:0] w_eff_ivl;
    logic                 r_tg_start;
    logic                 r_busy;
    logic                 r_done;
    logic [CNT_WIDTH-1:0] r_frames_sent;
    logic [CNT_WIDTH-1:0] r_late_cnt;
    logic                 w_accept;
    logic                 w_time_reached;
    logic                 w_count_reached;
    logic                 w_fire;
    logic                 w_late;
    logic                 w_set_done;

    // Stop beats start in IDLE; starts while busy are simply not accepted.
    assign w_accept        = (r_state == S_IDLE) && ctrl_start && !ctrl_stop;
    assign w_time_reached  = ({sec, nsec} >= {r_start_sec, r_start_nsec});
    assign w_count_reached = (r_frames != CNT_ZERO) && (r_frames_sent == r_frames);
    // Interval floor of 2 gives the generator one cycle to raise tg_busy.
    assign w_eff_ivl       = (r_ivl < IVL_MIN) ? IVL_MIN : r_ivl;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = S_ARMED;
                else          w_state_nxt = S_IDLE;
            end
            S_ARMED: begin
                if (ctrl_stop)           w_state_nxt = S_IDLE;
                else if (w_time_reached) w_state_nxt = S_ISSUE;
                else                     w_state_nxt = S_ARMED;
            end
            S_ISSUE: begin
                if (ctrl_stop)    w_state_nxt = S_IDLE;
                else if (tg_busy) w_state_nxt = S_ISSUE;
                else              w_state_nxt = S_GAP;
            end
            S_GAP: begin
                if (ctrl_stop || w_count_reached) w_state_nxt = S_IDLE;
                else if (r_timer == IVL_ZERO && tg_busy) w_state_nxt = S_ISSUE;
                else w_state_nxt = S_GAP;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Launch, late-slot and timer decisions. A free slot at timer 0 fires
    // straight from GAP so back-to-back launches keep exactly eff_ivl spacing;
    // a slot blocked by tg_busy falls back to ISSUE and waits there.
    always_comb begin
        w_fire      = 1'b0;
        w_late      = 1'b0;
        w_set_done  = 1'b0;
        w_timer_nxt = r_timer;
        case (r_state)
            S_ISSUE: begin
                if (!ctrl_stop && !tg_busy) begin
                    w_fire      = 1'b1;
                    w_timer_nxt = w_eff_ivl - IVL_ONE;
                end else begin
                    w_fire      = 1'b0;
                end
            end
            S_GAP: begin
                if (ctrl_stop) begin
                    w_timer_nxt = r_timer;
                end else if (w_count_reached) begin
                    w_set_done  = 1'b1;
                end else if (r_timer == IVL_ZERO) begin
                    if (tg_busy) begin
                        w_late      = 1'b1;
                    end else begin
                        w_fire      = 1'b1;
                        w_timer_nxt = w_eff_ivl - IVL_ONE;
                    end
                end else begin
                    w_timer_nxt = r_timer - IVL_ONE;
                end
            end
            default: w_timer_nxt = r_timer;
        endcase
    end

    // Registered outputs, counters, gap timer and shadow configuration.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tg_start    <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_frames_sent <= CNT_ZERO;
            r_late_cnt    <= CNT_ZERO;
            r_timer       <= IVL_ZERO;
            r_start_sec   <= 48'd0;
            r_start_nsec  <= 30'd0;
            r_frames      <= CNT_ZERO;
            r_ivl         <= IVL_ZERO;
        end else begin
            r_tg_start <= w_fire;
            r_busy     <= (w_state_nxt != S_IDLE);
            r_timer    <= w_timer_nxt;
            if (w_accept) begin
                r_start_sec   <= cfg_start_sec;
                r_start_nsec  <= cfg_start_nsec;
                r_frames      <= cfg_frames;
                r_ivl         <= cfg_interval;
                r_frames_sent <= CNT_ZERO;
                r_late_cnt    <= CNT_ZERO;
                r_done        <= 1'b0;
            end else begin
                if (w_fire)     r_frames_sent <= r_frames_sent + CNT_ONE;
                if (w_late)     r_late_cnt    <= r_late_cnt + CNT_ONE;
                if (w_set_done) r_done        <= 1'b1;
            end
        end
    end

    assign tg_start    = r_tg_start;
    assign busy        = r_busy;
    assign done        = r_done;
    assign frames_sent = r_frames_sent;
    assign late_cnt    = r_late_cnt;

endmodule

// File: tb/tb_traffic_scheduler_gmii.sv
// Directed, table-driven bench for traffic_scheduler_gmii with an rtclock
// model and an optional generator busy model.
module tb_traffic_scheduler_gmii;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [47:0] sec = 48'd5;
    logic [29:0] nsec = 30'd0;
    logic [47:0] cfg_start_sec = 48'd0;
    logic [29:0] cfg_start_nsec = 30'd0;
    logic [31:0] cfg_frames = 32'd0;
    logic [31:0] cfg_interval = 32'd0;
    logic        ctrl_start = 1'b0;
    logic        ctrl_stop = 1'b0;
    logic        tg_busy;
    logic        tg_start;
    logic        busy;
    logic        done;
    logic [31:0] frames_sent;
    logic [31:0] late_cnt;

    traffic_scheduler_gmii #(.CNT_WIDTH(32), .IVL_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .sec(sec), .nsec(nsec),
        .cfg_start_sec(cfg_start_sec), .cfg_start_nsec(cfg_start_nsec),
        .cfg_frames(cfg_frames), .cfg_interval(cfg_interval),
        .ctrl_start(ctrl_start), .ctrl_stop(ctrl_stop), .tg_busy(tg_busy),
        .tg_start(tg_start), .busy(busy), .done(done),
        .frames_sent(frames_sent), .late_cnt(late_cnt)
    );

    always #4 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int pulses[$];
    bit armed_flag = 1'b0;
    int arm_cyc = 0;
    int cmp_cyc = -1;

    // Generator model: busy for 100 cycles counted from the tg_start cycle.
    bit gen_en = 1'b0;
    int gen_cnt = 0;
    always @(posedge clk) begin
        if (tg_start && gen_en) gen_cnt <= 99;
        else if (gen_cnt != 0) gen_cnt <= gen_cnt - 1;
    end
    assign tg_busy = gen_en && (tg_start || gen_cnt != 0);

    always @(posedge clk) cyc++;

    // Pulse recorder, rtclock advance (8 ns per cycle) and compare-true model.
    always @(negedge clk) begin
        if (tg_start === 1'b1) pulses.push_back(cyc);
        if (nsec >= 30'd999999992) begin
            nsec = nsec - 30'd999999992;
            sec  = sec + 48'd1;
        end else begin
            nsec = nsec + 30'd8;
        end
        if (armed_flag && cmp_cyc < 0 && cyc >= arm_cyc + 1 &&
            {sec, nsec} >= {cfg_start_sec, cfg_start_nsec})
            cmp_cyc = cyc;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_start(input bit past, input int ahead);
        if (past) begin
            cfg_start_sec  = sec - 48'd1;
            cfg_start_nsec = nsec;
        end else begin
            cfg_start_sec  = sec;
            cfg_start_nsec = nsec + 30'(ahead);
        end
    endtask

    task automatic arm(input string name);
        tick();
        ctrl_start = 1'b1;
        cmp_cyc    = -1;
        arm_cyc    = cyc;
        pulses.delete();
        armed_flag = 1'b1;
        tick();
        ctrl_start = 1'b0;
        check({name, ".busy_after_arm"}, busy, 1);
    endtask

    task automatic wait_done(input string name, input int budget);
        int i = 0;
        while (done !== 1'b1 && i < budget) begin
            tick();
            i++;
        end
        check({name, ".done_reached"}, done, 1);
        check({name, ".busy_at_done"}, busy, 0);
        if (pulses.size() > 0) check({name, ".done_timing"}, cyc, pulses[pulses.size()-1] + 1);
    endtask

    task automatic wait_pulses(input string name, input int n, input int budget);
        int i = 0;
        while (pulses.size() < n && i < budget) begin
            tick();
            i++;
        end
        check({name, ".pulses_seen"}, pulses.size(), n);
    endtask

    task automatic check_spacing(input string name, input int sp);
        for (int i = 1; i < pulses.size(); i++)
            check($sformatf("%s.spacing%0d", name, i), pulses[i] - pulses[i-1], sp);
    endtask

    typedef struct {
        string name;
        int    frames;
        int    ivl;
        bit    past;
        int    ahead;
        bit    gen;
        int    exp_pulses;
        int    exp_spacing;
        int    exp_late;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{"ahead1000", 10, 84, 1'b0, 1000, 1'b0, 10, 84, 0};
        vecs[1] = '{"past_ivl0", 3, 0, 1'b1, 0, 1'b0, 3, 2, 0};
        vecs[2] = '{"gen_busy", 5, 84, 1'b0, 200, 1'b1, 5, 101, 4};
        vecs[3] = '{"ivl1_min", 2, 1, 1'b1, 0, 1'b0, 2, 2, 0};

        // Reset state.
        repeat (3) tick();
        check("reset.tg_start", tg_start, 0);
        check("reset.busy", busy, 0);
        check("reset.done", done, 0);
        check("reset.frames_sent", frames_sent, 0);
        check("reset.late_cnt", late_cnt, 0);
        rst = 1'b0;
        repeat (2) tick();

        // Table-driven complete runs.
        for (int v = 0; v < 4; v++) begin
            gen_en       = vecs[v].gen;
            cfg_frames   = 32'(vecs[v].frames);
            cfg_interval = 32'(vecs[v].ivl);
            set_start(vecs[v].past, vecs[v].ahead);
            arm(vecs[v].name);
            wait_done(vecs[v].name, vecs[v].exp_pulses * (vecs[v].exp_spacing + 4) + 400);
            check({vecs[v].name, ".pulse_count"}, pulses.size(), vecs[v].exp_pulses);
            if (pulses.size() > 0) check({vecs[v].name, ".first_latency"}, pulses[0] - cmp_cyc, 2);
            check_spacing(vecs[v].name, vecs[v].exp_spacing);
            check({vecs[v].name, ".frames_sent"}, frames_sent, vecs[v].exp_pulses);
            check({vecs[v].name, ".late_cnt"}, late_cnt, vecs[v].exp_late);
            armed_flag = 1'b0;
            gen_en = 1'b0;
            repeat (120) tick();
        end

        // ctrl_start while running with a new interval is ignored.
        cfg_frames = 32'd6;
        cfg_interval = 32'd84;
        set_start(1'b1, 0);
        arm("restart");
        wait_pulses("restart", 2, 300);
        cfg_interval = 32'd20;
        ctrl_start = 1'b1;
        tick();
        ctrl_start = 1'b0;
        wait_done("restart", 800);
        check("restart.pulse_count", pulses.size(), 6);
        check_spacing("restart", 84);
        check("restart.frames_sent", frames_sent, 6);
        armed_flag = 1'b0;
        repeat (5) tick();

        // Simultaneous start and stop in IDLE: nothing happens.
        ctrl_start = 1'b1;
        ctrl_stop  = 1'b1;
        tick();
        ctrl_start = 1'b0;
        ctrl_stop  = 1'b0;
        check("start_stop.busy", busy, 0);
        tick();
        check("start_stop.busy_later", busy, 0);
        check("start_stop.done_kept", done, 1);
        check("start_stop.frames_kept", frames_sent, 6);

        // Unlimited mode, stopped in the very cycle a launch would fire.
        cfg_frames = 32'd0;
        cfg_interval = 32'd10;
        set_start(1'b1, 0);
        arm("unlimited");
        wait_pulses("unlimited", 7, 200);
        repeat (9) tick();
        ctrl_stop = 1'b1;
        tick();
        ctrl_stop = 1'b0;
        check("unlimited.busy_after_stop", busy, 0);
        check("unlimited.tg_start_after_stop", tg_start, 0);
        repeat (30) tick();
        check("unlimited.pulse_count", pulses.size(), 7);
        check_spacing("unlimited", 10);
        check("unlimited.frames_sent", frames_sent, 7);
        check("unlimited.done", done, 0);
        check("unlimited.busy", busy, 0);
        armed_flag = 1'b0;

        // Reset while in GAP after two frames.
        cfg_frames = 32'd10;
        cfg_interval = 32'd84;
        set_start(1'b1, 0);
        arm("rst_gap");
        wait_pulses("rst_gap", 2, 300);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        check("rst_gap.tg_start", tg_start, 0);
        check("rst_gap.busy", busy, 0);
        check("rst_gap.done", done, 0);
        check("rst_gap.frames_sent", frames_sent, 0);
        check("rst_gap.late_cnt", late_cnt, 0);
        rst = 1'b0;
        repeat (100) tick();
        check("rst_gap.no_more_pulses", pulses.size(), 2);
        armed_flag = 1'b0;

        // Normal run after reset.
        cfg_frames = 32'd3;
        cfg_interval = 32'd5;
        set_start(1'b1, 0);
        arm("after_rst");
        wait_pulses("after_rst", 1, 50);
        check("after_rst.first_count", frames_sent, 1);
        wait_done("after_rst", 100);
        check("after_rst.pulse_count", pulses.size(), 3);
        if (pulses.size() > 0) check("after_rst.first_latency", pulses[0] - cmp_cyc, 2);
        check_spacing("after_rst", 5);
        check("after_rst.frames_sent", frames_sent, 3);
        armed_flag = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
